// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, class bit indices and reset PC for the fetch sequencer
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam int CLS_EBREAK = 0;
  localparam int CLS_ECALL  = 1;
  localparam int CLS_MRET   = 2;
  localparam int CLS_JAL    = 3;
  localparam int CLS_JALR   = 4;
  localparam int CLS_BEQ    = 5;
  localparam int CLS_BNE    = 6;
  localparam int CLS_BGE    = 7;
  localparam int CLS_BGEU   = 8;
  localparam int CLS_BLTU   = 9;
  localparam int CLS_BLT    = 10;
  localparam int CLS_SEQ    = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_RESOLVE,
    S_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - 32-bit saturating event counter with enable
module fetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer; FETCH_CTRL_PERF_EN enables the redirect-wait cycle counter
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic [31:0] pd_inst,
  input  logic [11:0] pd_class,
  input  logic        pd_not_jump,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halt,
  output logic [31:0] stall_cycles
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;

  // Only ebreak is decoded here; every other class reaches us folded into pd_not_jump.
  logic unused_inputs;
  assign unused_inputs = ^{pd_class[CLS_SEQ:CLS_ECALL], redirect_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    halt           = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d  = imem_resp_inst;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        id_valid = 1'b1;
        if (id_ready) begin
          if (pd_class[CLS_EBREAK]) begin
            state_d = S_HALT;
          end else if (pd_not_jump) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end else begin
            state_d = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        if (redirect_valid) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          state_d = S_REQ;
        end
      end
      S_HALT:  halt = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign pd_inst       = inst_q;
  assign id_inst       = inst_q;
  assign id_pc         = pc_q;

`ifdef FETCH_CTRL_PERF_EN
  fetch_perf_cnt u_perf_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (state_q == S_RESOLVE),
    .count_o(stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with a program-counter reference model
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic [31:0] pd_inst;
  logic [11:0] pd_class;
  logic        pd_not_jump;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] stall_cycles;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_stall = 0;

  logic        rs, ids, st;
  logic [31:0] ra, ii, ip;
  int          rw, nreq;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_inst (imem_resp_inst),
    .pd_inst        (pd_inst),
    .pd_class       (pd_class),
    .pd_not_jump    (pd_not_jump),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] stall_ref();
`ifdef FETCH_CTRL_PERF_EN
    return exp_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_inst = '0;
    id_ready = 1'b0; pd_class = '0; pd_not_jump = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    exp_stall = 0;
  endtask

  task automatic release_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic serve_req(input int lat, output logic seen, output logic [31:0] addr, output int waited);
    waited = 0;
    while (imem_req_valid !== 1'b1 && waited < 20) begin step(); waited++; end
    seen = (imem_req_valid === 1'b1);
    addr = imem_req_addr;
    repeat (lat) step();
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
  endtask

  task automatic serve_resp(input int lat, input logic [31:0] inst);
    repeat (lat) begin imem_resp_inst = $urandom; step(); end
    imem_resp_valid = 1'b1; imem_resp_inst = inst; step();
    imem_resp_valid = 1'b0; imem_resp_inst = $urandom;
  endtask

  task automatic serve_id(input int lat, input logic [11:0] cls, output logic seen,
                          output logic [31:0] inst, output logic [31:0] pc, output logic stable);
    seen = (id_valid === 1'b1); inst = id_inst; pc = id_pc; stable = 1'b1;
    pd_class = cls; pd_not_jump = cls[CLS_SEQ] | cls[CLS_EBREAK];
    repeat (lat) begin
      step();
      if (id_valid !== 1'b1 || id_inst !== inst || id_pc !== pc || imem_req_valid !== 1'b0) stable = 1'b0;
    end
    id_ready = 1'b1; step(); id_ready = 1'b0;
  endtask

  task automatic serve_redirect(input int lat, input logic [31:0] target, output int reqs);
    reqs = 0;
    repeat (lat) begin if (imem_req_valid === 1'b1) reqs++; step(); end
    if (imem_req_valid === 1'b1) reqs++;
    redirect_valid = 1'b1; redirect_pc = target; step();
    redirect_valid = 1'b0; redirect_pc = $urandom;
    exp_stall += 32'(lat + 1);
  endtask

  task automatic run_insn(input int rl, input int sl, input int il, input logic [31:0] inst, input logic [11:0] cls);
    serve_req(rl, rs, ra, rw);
    serve_resp(sl, inst);
    serve_id(il, cls, ids, ii, ip, st);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RPC); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    total++; if (id_inst !== 32'd0) begin bad++; $display("FAIL reset_id_inst got=%h exp=0", id_inst); end
    total++; if (id_pc !== RPC) begin bad++; $display("FAIL reset_id_pc got=%h exp=%h", id_pc, RPC); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    total++; if (pd_inst !== 32'd0) begin bad++; $display("FAIL reset_pd_inst got=%h exp=0", pd_inst); end
    release_reset();
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%b exp=1", imem_req_valid); end
    total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL first_req_addr got=%h exp=%h", imem_req_addr, RPC); end
  endtask

  task automatic test_sequential();
    int c0;
    logic [31:0] inst;
    for (int k = 0; k < 3; k++) begin
      inst = $urandom;
      c0 = cyc;
      run_insn(0, 0, 0, inst, 12'(1 << CLS_SEQ));
      total++; if (rs !== 1'b1 || rw !== 0) begin bad++; $display("FAIL seq_req_seen k=%0d got=%b wait=%0d exp=1 wait=0", k, rs, rw); end
      total++; if (ra !== RPC + 32'(4 * k)) begin bad++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, ra, RPC + 32'(4 * k)); end
      total++; if (ids !== 1'b1 || ii !== inst || ip !== ra) begin bad++; $display("FAIL seq_id k=%0d got=%b/%h/%h exp=1/%h/%h", k, ids, ii, ip, inst, ra); end
      total++; if (cyc - c0 !== 3 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL seq_rate k=%0d got=%0d cycles req=%b exp=3 req=1", k, cyc - c0, imem_req_valid); end
    end
    total++; if (pd_inst !== inst) begin bad++; $display("FAIL seq_pd_inst got=%h exp=%h", pd_inst, inst); end
  endtask

  task automatic test_hold();
    logic [31:0] inst;
    inst = $urandom;
    run_insn(1, 2, 5, inst, 12'(1 << CLS_SEQ));
    total++; if (st !== 1'b1) begin bad++; $display("FAIL hold_stable got=%b exp=1", st); end
    total++; if (ii !== inst || ip !== RPC + 32'hC) begin bad++; $display("FAIL hold_id got=%h/%h exp=%h/%h", ii, ip, inst, RPC + 32'hC); end
  endtask

  task automatic test_jal();
    run_insn(0, 0, 0, 32'h0F00_006F, 12'(1 << CLS_JAL));
    total++; if (ra !== RPC + 32'h10) begin bad++; $display("FAIL jal_addr got=%h exp=%h", ra, RPC + 32'h10); end
    serve_redirect(2, 32'h8000_0100, nreq);
    total++; if (nreq !== 0) begin bad++; $display("FAIL jal_no_req got=%0d exp=0", nreq); end
    total++; if (stall_cycles !== stall_ref()) begin bad++; $display("FAIL jal_stall got=%0d exp=%0d", stall_cycles, stall_ref()); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin bad++; $display("FAIL jal_target got=%b/%h exp=1/80000100", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_branch();
    run_insn(0, 1, 0, 32'h0000_0063, 12'(1 << CLS_BEQ));
    serve_redirect(0, 32'h8000_0014, nreq);
    total++; if (imem_req_addr !== 32'h8000_0014) begin bad++; $display("FAIL beq_nt_addr got=%h exp=80000014", imem_req_addr); end
    run_insn(0, 0, 0, 32'h0000_6063, 12'(1 << CLS_BLTU));
    serve_redirect(1, 32'h8000_0103, nreq);
    total++; if (imem_req_addr !== 32'h8000_0100) begin bad++; $display("FAIL align_addr got=%h exp=80000100", imem_req_addr); end
    run_insn(0, 0, 0, 32'h0000_0067, 12'(1 << CLS_JALR));
    serve_redirect(3, 32'hFFFF_FFFE, nreq);
    total++; if (imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL top_addr got=%h exp=fffffffc", imem_req_addr); end
    run_insn(0, 0, 0, 32'h0000_0013, 12'(1 << CLS_SEQ));
    total++; if (imem_req_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", imem_req_addr); end
    total++; if (stall_cycles !== stall_ref()) begin bad++; $display("FAIL branch_stall got=%0d exp=%0d", stall_cycles, stall_ref()); end
  endtask

  task automatic test_illegal_class();
    run_insn(0, 0, 0, $urandom, 12'h000);
    serve_redirect(2, 32'h8000_0200, nreq);
    total++; if (nreq !== 0 || imem_req_addr !== 32'h8000_0200) begin bad++; $display("FAIL zero_class got=%0d/%h exp=0/80000200", nreq, imem_req_addr); end
    run_insn(0, 0, 0, $urandom, 12'h808);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0204) begin bad++; $display("FAIL multi_seq got=%b/%h exp=1/80000204", imem_req_valid, imem_req_addr); end
    run_insn(0, 0, 0, $urandom, 12'h003);
    total++; if (halt !== 1'b1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL multi_ebreak got=%b/%b exp=1/0", halt, imem_req_valid); end
  endtask

  task automatic test_ebreak();
    do_reset();
    release_reset();
    run_insn(0, 0, 0, 32'h0010_0073, 12'(1 << CLS_EBREAK));
    total++; if (halt !== 1'b1 || ii !== 32'h0010_0073) begin bad++; $display("FAIL ebreak_halt got=%b/%h exp=1/00100073", halt, ii); end
    imem_req_ready = 1'b1; nreq = 0;
    repeat (10) begin step(); if (imem_req_valid === 1'b1 || halt !== 1'b1) nreq++; end
    imem_req_ready = 1'b0;
    total++; if (nreq !== 0) begin bad++; $display("FAIL halt_sticky got=%0d bad cycles exp=0", nreq); end
    do_reset();
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b exp=0", halt); end
    release_reset();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin bad++; $display("FAIL halt_restart got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RPC); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] inst;
    run_insn(0, 0, 0, $urandom, 12'(1 << CLS_SEQ));
    serve_req(0, rs, ra, rw);
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_inst = 32'hDEAD_BEEF;
    step(); step();
    rst = 1'b1;
    step();
    imem_resp_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin bad++; $display("FAIL midreset_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RPC); end
    total++; if (id_inst !== 32'd0) begin bad++; $display("FAIL stale_resp got=%h exp=0", id_inst); end
    inst = $urandom;
    run_insn(0, 0, 0, inst, 12'(1 << CLS_SEQ));
    total++; if (ii !== inst || ip !== RPC) begin bad++; $display("FAIL midreset_fetch got=%h/%h exp=%h/%h", ii, ip, inst, RPC); end
  endtask

  task automatic test_random();
    logic [31:0] pc_m, inst, tgt;
    logic [11:0] cls;
    int r, lat;
    do_reset();
    release_reset();
    pc_m = RPC;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5) cls = 12'(1 << CLS_SEQ);
      else if (r < 8) cls = 12'(1 << $urandom_range(CLS_ECALL, CLS_BLT));
      else if (r == 8) cls = 12'h000;
      else cls = 12'($urandom) & 12'hFFE;
      inst = $urandom;
      run_insn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), inst, cls);
      total++; if (rs !== 1'b1 || ra !== pc_m) begin bad++; $display("FAIL rnd_addr n=%0d got=%b/%h exp=1/%h", n, rs, ra, pc_m); end
      total++; if (ii !== inst || ip !== pc_m) begin bad++; $display("FAIL rnd_id n=%0d got=%h/%h exp=%h/%h", n, ii, ip, inst, pc_m); end
      if (cls[CLS_SEQ]) begin
        pc_m = pc_m + 32'd4;
      end else begin
        tgt = $urandom;
        lat = $urandom_range(0, 4);
        serve_redirect(lat, tgt, nreq);
        total++; if (nreq !== 0) begin bad++; $display("FAIL rnd_resolve_req n=%0d got=%0d exp=0", n, nreq); end
        pc_m = tgt & 32'hFFFF_FFFC;
      end
    end
    run_insn(0, 0, 0, 32'h0010_0073, 12'(1 << CLS_EBREAK));
    total++; if (ra !== pc_m || halt !== 1'b1) begin bad++; $display("FAIL rnd_end got=%h/%b exp=%h/1", ra, halt, pc_m); end
    total++; if (stall_cycles !== stall_ref()) begin bad++; $display("FAIL rnd_stall got=%0d exp=%0d", stall_cycles, stall_ref()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_jal();
    test_branch();
    test_illegal_class();
    test_ebreak();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
